// File: rtl/ledpanel_fb_writer.sv
// ledpanel_fb_writer: writer side of the double-buffered bit-plane framebuffer.
// Takes an RGB pixel stream in raster order and writes each pixel as one
// masked 6-bit word per bit plane into the back buffer. The top and bottom
// panel halves share a word: top pixel in [5:3], bottom pixel in [2:0].
// When a frame completes, the buffer select toggles and frame_done pulses.
//
// Ports:
//   clk, ctrl_rst          clock, synchronous active-high reset
//   ctrl_en                enable; low returns the block to IDLE
//   ctrl_n_rows/n_cols/bitdepth  frame geometry, sampled on the SOF pixel
//   pix_valid/ready/sof/data     pixel stream, {R,G,B} with each channel MSB-aligned
//   mem_wr_*               BRAM write port (buffer, word address, plane, data, mask)
//   frame_done             one-cycle pulse when a frame has been fully written
//   frame_err              one-cycle pulse when SOF arrives in the middle of a frame
module ledpanel_fb_writer #(
  parameter int unsigned N_ROWS_MAX       = 64,
  parameter int unsigned N_COLS_MAX       = 256,
  parameter int unsigned BITDEPTH_MAX     = 8,
  parameter int unsigned W_MEM_ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX)-1,
  parameter int unsigned W_MEM_DATA_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            ctrl_rst,
  input  logic                            ctrl_en,
  input  logic [31:0]                     ctrl_n_rows,
  input  logic [31:0]                     ctrl_n_cols,
  input  logic [31:0]                     ctrl_bitdepth,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic                            pix_sof,
  input  logic [3*BITDEPTH_MAX-1:0]       pix_data,
  output logic                            mem_wr_en,
  output logic                            mem_wr_buffer,
  output logic [W_MEM_ADDR_WIDTH-1:0]     mem_wr_addr,
  output logic [$clog2(BITDEPTH_MAX)-1:0] mem_wr_bit,
  output logic [W_MEM_DATA_WIDTH-1:0]     mem_wr_data,
  output logic [W_MEM_DATA_WIDTH-1:0]     mem_wr_mask,
  output logic                            frame_done,
  output logic                            frame_err
);

  localparam int unsigned PIX_W = 3*BITDEPTH_MAX;
  localparam int unsigned BIT_W = $clog2(BITDEPTH_MAX);
  localparam int unsigned BD_W  = $clog2(BITDEPTH_MAX+1);
  localparam int unsigned ROW_W = $clog2(N_ROWS_MAX+1);
  localparam int unsigned COL_W = $clog2(N_COLS_MAX+1);
  localparam int unsigned AW    = W_MEM_ADDR_WIDTH;
  localparam int unsigned DW    = W_MEM_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [BIT_W-1:0]   plane_q, plane_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               top_q, top_d;
  logic [ROW_W-1:0]   n_rows_q, n_rows_d;
  logic [COL_W-1:0]   n_cols_q, n_cols_d;
  logic [BD_W-1:0]    bd_q, bd_d;
  logic               wbuf_q, wbuf_d;
  logic               pix_ready_q, pix_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [BIT_W-1:0]   wr_bit_q, wr_bit_d;
  logic [DW-1:0]      wr_data_q, wr_data_d;
  logic [DW-1:0]      wr_mask_q, wr_mask_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;

  logic               hs;
  logic               capture;
  logic               last_plane;
  logic [ROW_W-1:0]   half;
  logic [ROW_W-1:0]   row_half;
  logic [AW-1:0]      addr_calc;
  logic [BD_W-1:0]    bidx_w;
  logic [BIT_W-1:0]   bidx;
  logic [BITDEPTH_MAX-1:0] ch_r, ch_g, ch_b;
  logic [2:0]         rgb;

  // Upper config bits are beyond the legal range and intentionally ignored.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{ctrl_n_rows[31:ROW_W], ctrl_n_cols[31:COL_W],
                             ctrl_bitdepth[31:BD_W]};

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    plane_d      = plane_q;
    pix_d        = pix_q;
    addr_d       = addr_q;
    top_d        = top_q;
    n_rows_d     = n_rows_q;
    n_cols_d     = n_cols_q;
    bd_d         = bd_q;
    wbuf_d       = wbuf_q;
    pix_ready_d  = 1'b0;
    wr_en_d      = 1'b0;
    wr_bit_d     = '0;
    wr_data_d    = '0;
    wr_mask_d    = '0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    capture      = 1'b0;

    hs         = ctrl_en && pix_valid && pix_ready_q;
    last_plane = (BD_W'(plane_q) == (bd_q - BD_W'(1)));
    half       = n_rows_q >> 1;
    row_half   = (row_q >= half) ? (row_q - half) : row_q;
    addr_calc  = AW'(AW'(row_half) * AW'(n_cols_q)) + AW'(col_q);

    unique case (state_q)
      S_IDLE: begin
        // Beats before the first SOF are swallowed.
        if (hs && pix_sof) capture = 1'b1;
      end
      S_ACCEPT: begin
        if (hs) begin
          capture     = 1'b1;
          frame_err_d = pix_sof;
        end
      end
      S_WRITE: begin
        if (!last_plane) begin
          plane_d = plane_q + BIT_W'(1);
        end else if (col_q < (n_cols_q - COL_W'(1))) begin
          col_d   = col_q + COL_W'(1);
          state_d = S_ACCEPT;
        end else if (row_q < (n_rows_q - ROW_W'(1))) begin
          col_d   = '0;
          row_d   = row_q + ROW_W'(1);
          state_d = S_ACCEPT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        wbuf_d       = ~wbuf_q;
        row_d        = '0;
        col_d        = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pixel capture; SOF restarts at (0,0) with freshly latched geometry.
    if (capture) begin
      pix_d   = pix_data;
      plane_d = '0;
      state_d = S_WRITE;
      if (pix_sof) begin
        n_rows_d = ROW_W'(ctrl_n_rows);
        n_cols_d = COL_W'(ctrl_n_cols);
        bd_d     = BD_W'(ctrl_bitdepth);
        row_d    = '0;
        col_d    = '0;
        addr_d   = '0;
        top_d    = 1'b1;
      end else begin
        addr_d = addr_calc;
        top_d  = (row_q < half);
      end
    end

    // Plane k reads channel bit BITDEPTH_MAX-bitdepth+k, so plane 0 is the used LSB.
    bidx_w = BD_W'(BITDEPTH_MAX) - bd_d + BD_W'(plane_d);
    bidx   = BIT_W'(bidx_w);
    ch_r   = pix_d[3*BITDEPTH_MAX-1:2*BITDEPTH_MAX];
    ch_g   = pix_d[2*BITDEPTH_MAX-1:BITDEPTH_MAX];
    ch_b   = pix_d[BITDEPTH_MAX-1:0];
    rgb    = {ch_r[bidx], ch_g[bidx], ch_b[bidx]};

    if (state_d == S_WRITE) begin
      wr_en_d  = 1'b1;
      wr_bit_d = plane_d;
      if (top_d) begin
        wr_data_d = DW'({rgb, 3'b000});
        wr_mask_d = DW'(6'b111000);
      end else begin
        wr_data_d = DW'({3'b000, rgb});
        wr_mask_d = DW'(6'b000111);
      end
    end

    pix_ready_d = (state_d == S_IDLE) || (state_d == S_ACCEPT);

    // Disable abandons the frame but keeps the buffer select.
    if (!ctrl_en) begin
      state_d      = S_IDLE;
      row_d        = '0;
      col_d        = '0;
      plane_d      = '0;
      wbuf_d       = wbuf_q;
      pix_ready_d  = 1'b0;
      wr_en_d      = 1'b0;
      wr_bit_d     = '0;
      wr_data_d    = '0;
      wr_mask_d    = '0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (ctrl_rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      plane_q      <= '0;
      pix_q        <= '0;
      addr_q       <= '0;
      top_q        <= 1'b0;
      n_rows_q     <= '0;
      n_cols_q     <= '0;
      bd_q         <= '0;
      wbuf_q       <= 1'b1;
      pix_ready_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bit_q     <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      pix_q        <= pix_d;
      addr_q       <= addr_d;
      top_q        <= top_d;
      n_rows_q     <= n_rows_d;
      n_cols_q     <= n_cols_d;
      bd_q         <= bd_d;
      wbuf_q       <= wbuf_d;
      pix_ready_q  <= pix_ready_d;
      wr_en_q      <= wr_en_d;
      wr_bit_q     <= wr_bit_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign pix_ready     = pix_ready_q;
  assign mem_wr_en     = wr_en_q;
  assign mem_wr_buffer = wbuf_q;
  assign mem_wr_addr   = addr_q;
  assign mem_wr_bit    = wr_bit_q;
  assign mem_wr_data   = wr_data_q;
  assign mem_wr_mask   = wr_mask_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ledpanel_fb_writer.sv
// Scoreboard bench for ledpanel_fb_writer: a reference model pushes the
// expected write words per accepted pixel; a negedge monitor pops and compares.
module tb_ledpanel_fb_writer;

  logic        clk = 1'b0;
  logic        ctrl_rst;
  logic        ctrl_en;
  logic [31:0] ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth;
  logic        pix_valid, pix_ready, pix_sof;
  logic [23:0] pix_data;
  logic        mem_wr_en, mem_wr_buffer;
  logic [12:0] mem_wr_addr;
  logic [2:0]  mem_wr_bit;
  logic [5:0]  mem_wr_data, mem_wr_mask;
  logic        frame_done, frame_err;

  ledpanel_fb_writer dut (
    .clk(clk), .ctrl_rst(ctrl_rst), .ctrl_en(ctrl_en),
    .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols), .ctrl_bitdepth(ctrl_bitdepth),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
    .mem_wr_en(mem_wr_en), .mem_wr_buffer(mem_wr_buffer), .mem_wr_addr(mem_wr_addr),
    .mem_wr_bit(mem_wr_bit), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_seen = 0, err_seen = 0, wr_count = 0;
  int done_exp  = 0, err_exp  = 0;
  int last_hs = 0, prev_hs = 0;

  // Reference model state
  int m_nr, m_nc, m_bd, m_row, m_col;
  bit m_in_frame = 1'b0;
  bit m_wbuf     = 1'b1;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected packed write word {buffer, addr, bit, data, mask}.
  function automatic logic [31:0] exp_word(input logic [23:0] p, input int bd, input int k,
                                           input int row, input int col, input int nr,
                                           input int nc, input bit wb);
    int b, half, a;
    logic [23:0] s;
    logic [2:0]  rgb;
    logic [5:0]  d, m;
    b    = 8 - bd + k;
    s    = p >> b;
    rgb  = {s[16], s[8], s[0]};
    half = nr / 2;
    if (row < half) begin d = {rgb, 3'b000}; m = 6'b111000; end
    else            begin d = {3'b000, rgb}; m = 6'b000111; end
    a = (row % half) * nc + col;
    return 32'({wb, 13'(a), 3'(k), d, m});
  endfunction

  task automatic model_pixel(input logic [23:0] p, input bit sof);
    if (!m_in_frame && !sof) return;
    if (sof) begin
      if (m_in_frame) err_exp++;
      m_nr = int'(ctrl_n_rows); m_nc = int'(ctrl_n_cols); m_bd = int'(ctrl_bitdepth);
      m_row = 0; m_col = 0; m_in_frame = 1'b1;
    end
    for (int k = 0; k < m_bd; k++)
      exp_q.push_back(exp_word(p, m_bd, k, m_row, m_col, m_nr, m_nc, m_wbuf));
    if (m_col < m_nc - 1) m_col++;
    else if (m_row < m_nr - 1) begin m_col = 0; m_row++; end
    else begin
      done_exp++; m_wbuf = ~m_wbuf; m_in_frame = 1'b0; m_row = 0; m_col = 0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  always @(negedge clk) begin
    if (!ctrl_rst) begin
      if (frame_done) done_seen++;
      if (frame_err)  err_seen++;
      if (mem_wr_en) begin
        wr_count++;
        check_eq("wr_ready_low", 32'(pix_ready), 32'd0);
        if (exp_q.size() == 0)
          check_eq("unexpected_wr", 32'({mem_wr_buffer, mem_wr_addr, mem_wr_bit, mem_wr_data, mem_wr_mask}), 32'd0);
        else
          check_eq("wr_word", 32'({mem_wr_buffer, mem_wr_addr, mem_wr_bit, mem_wr_data, mem_wr_mask}),
                   exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_pix(input logic [23:0] p, input bit sof);
    int n;
    bit writes;
    pix_data = p; pix_sof = sof; pix_valid = 1'b1;
    n = 0;
    while (!pix_ready && n < 200) begin @(negedge clk); n++; end
    if (!pix_ready) begin
      check_eq("ready_timeout", 32'(pix_ready), 32'd1);
      pix_valid = 1'b0; pix_sof = 1'b0;
      return;
    end
    writes = sof || m_in_frame;
    model_pixel(p, sof);
    prev_hs = last_hs; last_hs = cyc;
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
    @(negedge clk);
    if (writes) check_eq("first_wr_lat", 32'({mem_wr_en, mem_wr_bit}), 32'({1'b1, 3'd0}));
    else        check_eq("idle_no_wr", 32'(mem_wr_en), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic set_cfg(input int nr, input int nc, input int bd);
    ctrl_n_rows = 32'(nr); ctrl_n_cols = 32'(nc); ctrl_bitdepth = 32'(bd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, d0, e0, n;
    ctrl_rst = 1'b1; ctrl_en = 1'b1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    set_cfg(4, 2, 8);
    repeat (3) @(negedge clk);
    check_eq("reset_outs",
      32'({pix_ready, mem_wr_en, mem_wr_addr, mem_wr_bit, mem_wr_data, mem_wr_mask,
           frame_done, frame_err, mem_wr_buffer}),
      32'({1'b0, 1'b0, 13'd0, 3'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1}));
    ctrl_rst = 1'b0;

    // Frame A: 4x2, 8 bits; pixel (2,1) is 0xFF0080; mid-frame config change ignored.
    for (int i = 0; i < 8; i++) begin
      send_pix((i == 5) ? 24'hFF0080 : 24'($urandom), i == 0);
      if (i == 0) ctrl_n_cols = 32'd7;
    end
    drain();
    check_eq("frameA_done", 32'(done_seen), 32'(done_exp));
    check_eq("frameA_swap", 32'(mem_wr_buffer), 32'(m_wbuf));

    // Frame B: 2x2, 4 bits, top pixel R=0xF0.
    set_cfg(2, 2, 4);
    wr0 = wr_count;
    send_pix(24'hF00000, 1'b1);
    send_pix(24'($urandom), 1'b0);
    check_eq("throughput_gap", 32'(last_hs - prev_hs), 32'd5);
    send_pix(24'($urandom), 1'b0);
    send_pix(24'($urandom), 1'b0);
    drain();
    check_eq("frameB_writes", 32'(wr_count - wr0), 32'd16);
    check_eq("frameB_done", 32'(done_seen), 32'(done_exp));
    check_eq("frameB_swap", 32'(mem_wr_buffer), 32'(m_wbuf));

    // Beats without SOF while idle are dropped.
    wr0 = wr_count; d0 = done_seen;
    for (int i = 0; i < 3; i++) send_pix(24'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    check_eq("idle_beats_wr", 32'(wr_count - wr0), 32'd0);
    check_eq("idle_beats_done", 32'(done_seen - d0), 32'd0);

    // SOF on the 3rd pixel restarts the frame in the same buffer.
    set_cfg(2, 2, 2);
    e0 = err_seen;
    send_pix(24'($urandom), 1'b1);
    send_pix(24'($urandom), 1'b0);
    send_pix(24'($urandom), 1'b1);
    send_pix(24'($urandom), 1'b0);
    send_pix(24'($urandom), 1'b0);
    repeat (2) @(negedge clk);
    check_eq("midsof_err", 32'(err_seen - e0), 32'd1);
    check_eq("midsof_no_done", 32'(done_seen), 32'(done_exp));
    check_eq("midsof_buf_held", 32'(mem_wr_buffer), 32'(m_wbuf));
    send_pix(24'($urandom), 1'b0);
    drain();
    check_eq("midsof_done", 32'(done_seen), 32'(done_exp));
    check_eq("midsof_swap", 32'(mem_wr_buffer), 32'(m_wbuf));

    // Reset in the middle of a pixel write at plane 3.
    set_cfg(2, 2, 8);
    d0 = done_seen;
    send_pix(24'($urandom), 1'b1);
    n = 0;
    while (!(mem_wr_en && mem_wr_bit == 3'd3) && n < 50) begin @(negedge clk); n++; end
    check_eq("rst_reach_plane3", 32'(mem_wr_bit), 32'd3);
    ctrl_rst = 1'b1;
    @(negedge clk);
    check_eq("rst_midwrite",
      32'({mem_wr_en, pix_ready, mem_wr_buffer, frame_done}), 32'({1'b0, 1'b0, 1'b1, 1'b0}));
    ctrl_rst = 1'b0;
    exp_q.delete();
    m_in_frame = 1'b0; m_wbuf = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_no_done", 32'(done_seen - d0), 32'd0);

    // ctrl_en low for 5 cycles mid-frame, then restart with SOF.
    set_cfg(2, 2, 2);
    e0 = err_seen;
    send_pix(24'($urandom), 1'b1);
    send_pix(24'($urandom), 1'b0);
    drain();
    ctrl_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("en_low_quiet", 32'({pix_ready, mem_wr_en}), 32'd0);
    end
    m_in_frame = 1'b0;
    ctrl_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_eq("en_no_done_early", 32'(done_seen), 32'(done_exp));
      send_pix(24'($urandom), i == 0);
    end
    drain();
    check_eq("en_no_err", 32'(err_seen - e0), 32'd0);
    check_eq("en_done", 32'(done_seen), 32'(done_exp));
    check_eq("en_swap", 32'(mem_wr_buffer), 32'(m_wbuf));

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("err_total", 32'(err_seen), 32'(err_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
